pattern_det_n: RTL

Parametrised serial pattern detector, the successor to the fixed two-input Mano-style detector. It samples one SYM_W-bit symbol per enabled clock and compares the last DEPTH symbols against a pattern supplied on a port. It raises a one-cycle registered match pulse and keeps a saturating match count. Overlapping matches can be counted or suppressed at run time. It sits between a symbol source and any consumer of match events in the sequential-logic exercises, and is exercised by a self-checking bench alongside a reference model.

---
 rtl/pattern_det_n.sv | 93 +++++++++
 1 files changed

// File: rtl/pattern_det_n.sv
// Serial pattern detector: compares the last DEPTH symbols against pat_i,
// emits a registered match pulse and keeps a saturating match count.
module pattern_det_n #(
    parameter int SYM_W = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   clr_i,
    input  logic                   overlap_i,
    input  logic [SYM_W-1:0]       x_i,
    input  logic [SYM_W*DEPTH-1:0] pat_i,
    output logic                   y_out,
    output logic [CNT_W-1:0]       cnt_out,
    output logic [1:0]             state_out
);

    localparam int HW = SYM_W * DEPTH;
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        ARMED = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hist_q, hist_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic              y_q, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // State, history, fill, pulse and counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            y_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shift/fill update, match evaluation on next-state values, FSM next state
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        y_d     = 1'b0;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (en_i) begin
            hist_d = {x_i, hist_q[HW-1:SYM_W]};
            if (fill_q != FULL) begin
                fill_d = fill_q + 1'b1;
            end
            if (fill_d == FULL && hist_d == pat_i) begin
                y_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Non-overlapping mode demands a full refill before the next hit
                if (!overlap_i) begin
                    fill_d = '0;
                end
            end
        end
        if (fill_d == '0) begin
            state_d = IDLE;
        end else if (fill_d == FULL) begin
            state_d = ARMED;
        end else begin
            state_d = FILL;
        end
    end

    assign y_out     = y_q;
    assign cnt_out   = cnt_q;
    assign state_out = state_q;

endmodule
